// File: rtl/matrix_result_serializer.sv
// -----------------------------------------------------------------------------
// matrix_result_serializer
//
// Purpose:
//   Sits downstream of the floating-point matrix multiplier. Captures the flat
//   result matrix in one shot using the multiplier's four-phase
//   out_ready/out_ack handshake. It then streams the elements one word per beat
//   over a valid/ready interface. The multiplier is released as soon as the
//   matrix is captured, so the next multiplication can overlap with streaming.
//   Elements pass through bit-exact; no arithmetic is done on them.
//
// Build option:
//   SERIALIZER_COL_MAJOR_EN - when defined, beats leave in column-major order
//                             (beat j = element (j % NUM_ROWS)*NUM_COLS +
//                             j / NUM_ROWS). When undefined, beats leave in
//                             row-major order (beat j = element j).
//                             Handshake, latency and m_last are the same in
//                             both builds.
//
// Parameters:
//   NUM_ROWS   - rows of the result matrix
//   NUM_COLS   - columns of the result matrix
//   WORD_WIDTH - bits per element
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-low reset
//   res_data  in   result matrix, element k at [k*WORD_WIDTH +: WORD_WIDTH]
//   res_ready in   multiplier out_ready (result valid while high)
//   res_ack   out  multiplier out_ack
//   m_data    out  streamed element
//   m_valid   out  m_data valid
//   m_ready   in   sink accepts the beat when m_valid && m_ready
//   m_last    out  final beat of the matrix
//   m_index   out  beat number within the matrix (0..ELEMS-1)
//   busy      out  a captured matrix is not fully streamed yet
// -----------------------------------------------------------------------------
module matrix_result_serializer #(
    parameter  int NUM_ROWS   = 2,
    parameter  int NUM_COLS   = 2,
    parameter  int WORD_WIDTH = 32,
    localparam int ELEMS      = NUM_ROWS * NUM_COLS,
    localparam int IDXW       = (ELEMS > 1) ? $clog2(ELEMS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ELEMS*WORD_WIDTH-1:0] res_data,
    input  logic                        res_ready,
    output logic                        res_ack,
    output logic [WORD_WIDTH-1:0]       m_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic                        m_last,
    output logic [IDXW-1:0]             m_index,
    output logic                        busy
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(ELEMS - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t                  state_reg;
    state_t                  state_next;
    logic                    res_ack_reg;
    logic [IDXW-1:0]         idx_reg;
    logic [IDXW-1:0]         idx_plus;
    logic [WORD_WIDTH-1:0]   m_data_reg;
    logic [WORD_WIDTH-1:0]   next_word;

    // Buffer is held in output (beat) order, so the streaming side never
    // needs to know which ordering the build uses.
    logic [WORD_WIDTH-1:0]   buffer_reg [ELEMS];
    logic [WORD_WIDTH-1:0]   beat_src   [ELEMS];

    logic                    capture;
    logic                    accept;
    logic                    last_beat;

    // -------------------------------------------------------------------------
    // Handshake qualifiers
    // -------------------------------------------------------------------------
    // A capture needs the previous ack to have been withdrawn, so one result
    // held on res_ready for many cycles is only taken once.
    assign capture   = (state_reg == IDLE) && res_ready && !res_ack_reg;
    assign accept    = (state_reg == STREAM) && m_ready;
    assign last_beat = accept && (idx_reg == LAST_IDX);
    assign idx_plus  = idx_reg + IDXW'(1);

    // -------------------------------------------------------------------------
    // Beat-order reordering of the incoming matrix (pure wiring)
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < ELEMS; gi++) begin : g_beat_map
`ifdef SERIALIZER_COL_MAJOR_EN
        localparam int SRC = (gi % NUM_ROWS) * NUM_COLS + (gi / NUM_ROWS);
`else
        localparam int SRC = gi;
`endif
        assign beat_src[gi] = res_data[SRC*WORD_WIDTH +: WORD_WIDTH];
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (capture) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                if (last_beat) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        m_valid = (state_reg == STREAM);
        busy    = (state_reg == STREAM);
        m_last  = (state_reg == STREAM) && (idx_reg == LAST_IDX);
        res_ack = res_ack_reg;
        m_data  = m_data_reg;
        m_index = idx_reg;
    end

    // -------------------------------------------------------------------------
    // Four-phase ack: raised on capture, dropped once res_ready is seen low.
    // Runs independently of the streaming side.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_ack_reg <= 1'b0;
        end else if (capture) begin
            res_ack_reg <= 1'b1;
        end else if (res_ack_reg && !res_ready) begin
            res_ack_reg <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Beat counter: only ever returns to 0 explicitly (capture or last beat).
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_reg <= '0;
        end else if (capture || last_beat) begin
            idx_reg <= '0;
        end else if (accept) begin
            idx_reg <= idx_plus;
        end
    end

    // -------------------------------------------------------------------------
    // Matrix buffer
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ELEMS; i++) begin
                buffer_reg[i] <= '0;
            end
        end else if (capture) begin
            for (int i = 0; i < ELEMS; i++) begin
                buffer_reg[i] <= beat_src[i];
            end
        end
    end

    // Word for the beat after the current one. The range check keeps the
    // select inside the buffer when ELEMS is not a power of two.
    always_comb begin
        next_word = '0;
        for (int i = 0; i < ELEMS; i++) begin
            if (idx_plus == IDXW'(i)) begin
                next_word = buffer_reg[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registered output word. The first beat comes straight from res_data so
    // it is presented the cycle after capture; later beats come from the
    // buffer. The word only changes on an accepted beat, so it holds through
    // stalls.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_data_reg <= '0;
        end else if (capture) begin
            m_data_reg <= beat_src[0];
        end else if (accept && !last_beat) begin
            m_data_reg <= next_word;
        end
    end

endmodule

// File: tb/tb_matrix_result_serializer.sv
// -----------------------------------------------------------------------------
// Bench for matrix_result_serializer. Two instances share rst, res_ready and
// m_ready: a 2x2 instance and a non-square 2x3 instance. A queue-based model
// of each instance predicts the outputs, and a compare process checks them at
// every falling edge. Directed literal checks pin the model.
// -----------------------------------------------------------------------------
module tb_matrix_result_serializer;

    localparam int W = 32;
`ifdef SERIALIZER_COL_MAJOR_EN
    localparam bit COL_MAJOR = 1'b1;
`else
    localparam bit COL_MAJOR = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           res_ready;
    logic           m_ready;
    logic [4*W-1:0] sq_res_data;
    logic [6*W-1:0] ns_res_data;

    logic           sq_ack, sq_valid, sq_last, sq_busy;
    logic [W-1:0]   sq_data;
    logic [1:0]     sq_idx;
    logic           ns_ack, ns_valid, ns_last, ns_busy;
    logic [W-1:0]   ns_data;
    logic [2:0]     ns_idx;

    int n_checks = 0;
    int n_errors = 0;

    // Model state, one entry per instance (0 = 2x2, 1 = 2x3)
    logic [31:0] exp_q [2][$];
    bit          exp_ack [2];
    int          exp_idx [2];

    always #5 clk = ~clk;

    matrix_result_serializer #(.NUM_ROWS(2), .NUM_COLS(2), .WORD_WIDTH(W)) u_sq (
        .clk(clk), .rst(rst), .res_data(sq_res_data), .res_ready(res_ready),
        .res_ack(sq_ack), .m_data(sq_data), .m_valid(sq_valid), .m_ready(m_ready),
        .m_last(sq_last), .m_index(sq_idx), .busy(sq_busy)
    );

    matrix_result_serializer #(.NUM_ROWS(2), .NUM_COLS(3), .WORD_WIDTH(W)) u_ns (
        .clk(clk), .rst(rst), .res_data(ns_res_data), .res_ready(res_ready),
        .res_ack(ns_ack), .m_data(ns_data), .m_valid(ns_valid), .m_ready(m_ready),
        .m_last(ns_last), .m_index(ns_idx), .busy(ns_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic string nm(input int i);
        return (i == 0) ? "sq" : "ns";
    endfunction

    task automatic reset_model();
        for (int i = 0; i < 2; i++) begin
            exp_q[i].delete();
            exp_ack[i] = 1'b0;
            exp_idx[i] = 0;
        end
    endtask

    // Predict the effect of the coming rising edge, given the inputs that
    // will be sampled there.
    task automatic advance(input int i, input logic [6*W-1:0] d);
        int nr, nc, e;
        bit streaming;
        nr = 2;
        nc = (i == 0) ? 2 : 3;
        e  = nr * nc;
        streaming = (exp_q[i].size() > 0);
        if (streaming && m_ready) begin
            void'(exp_q[i].pop_front());
            exp_idx[i] = (exp_q[i].size() == 0) ? 0 : exp_idx[i] + 1;
        end
        if (!streaming && res_ready && !exp_ack[i]) begin
            for (int j = 0; j < e; j++) begin
                int k;
                k = COL_MAJOR ? ((j % nr) * nc + j / nr) : j;
                exp_q[i].push_back(d[k*W +: W]);
            end
            exp_ack[i] = 1'b1;
            exp_idx[i] = 0;
        end else if (exp_ack[i] && !res_ready) begin
            exp_ack[i] = 1'b0;
        end
    endtask

    task automatic compare_inst(input int i, input logic ack, input logic valid,
                                input logic last, input logic bsy,
                                input logic [2:0] idx, input logic [31:0] data);
        bit s;
        s = (exp_q[i].size() > 0);
        chk($sformatf("%s res_ack", nm(i)), 32'(ack), 32'(exp_ack[i]));
        chk($sformatf("%s m_valid", nm(i)), 32'(valid), 32'(s));
        chk($sformatf("%s busy", nm(i)), 32'(bsy), 32'(s));
        chk($sformatf("%s m_last", nm(i)), 32'(last), 32'(s && exp_q[i].size() == 1));
        chk($sformatf("%s m_index", nm(i)), 32'(idx), 32'(exp_idx[i]));
        if (s) begin
            chk($sformatf("%s m_data", nm(i)), data, exp_q[i][0]);
        end
    endtask

    // Compare process: falling edge, away from the sampling edge.
    initial begin
        reset_model();
        forever begin
            @(negedge clk);
            if (!rst) reset_model();
            compare_inst(0, sq_ack, sq_valid, sq_last, sq_busy, {1'b0, sq_idx}, sq_data);
            compare_inst(1, ns_ack, ns_valid, ns_last, ns_busy, ns_idx, ns_data);
            if (rst) begin
                advance(0, {64'b0, sq_res_data});
                advance(1, ns_res_data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] sq_lit [4];
    logic [31:0] ns_lit [6];
    bit          pat [7];
    int          acc_sq, acc_ns, caps;
    bit          prev_valid, saw_idle, recaptured;

    initial begin
`ifdef SERIALIZER_COL_MAJOR_EN
        sq_lit = '{32'h40E00000, 32'h41700000, 32'h41200000, 32'h41B00000};
        ns_lit = '{32'h3F800000, 32'h40800000, 32'h40000000,
                   32'h40A00000, 32'h40400000, 32'h40C00000};
`else
        sq_lit = '{32'h40E00000, 32'h41200000, 32'h41700000, 32'h41B00000};
        ns_lit = '{32'h3F800000, 32'h40000000, 32'h40400000,
                   32'h40800000, 32'h40A00000, 32'h40C00000};
`endif
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        rst         = 1'b0;
        res_ready   = 1'b0;
        m_ready     = 1'b0;
        sq_res_data = '0;
        ns_res_data = '0;

        // Reset state
        repeat (3) step();
        chk("reset sq m_valid", 32'(sq_valid), 32'd0);
        chk("reset sq res_ack", 32'(sq_ack), 32'd0);
        chk("reset sq m_data", sq_data, 32'd0);
        chk("reset ns m_index", 32'(ns_idx), 32'd0);
        rst = 1'b1;
        step();

        // Basic stream, m_ready held high
        sq_res_data = {32'h41B00000, 32'h41700000, 32'h41200000, 32'h40E00000};
        ns_res_data = {32'h40C00000, 32'h40A00000, 32'h40800000,
                       32'h40400000, 32'h40000000, 32'h3F800000};
        res_ready = 1'b1;
        m_ready   = 1'b1;
        step();
        chk("basic sq res_ack", 32'(sq_ack), 32'd1);
        chk("basic sq first valid", 32'(sq_valid), 32'd1);
        chk("basic sq first index", 32'(sq_idx), 32'd0);
        res_ready = 1'b0;
        for (int b = 0; b < 6; b++) begin
            if (b < 4) begin
                chk($sformatf("basic sq beat%0d data", b), sq_data, sq_lit[b]);
                chk($sformatf("basic sq beat%0d last", b), 32'(sq_last), 32'(b == 3));
            end
            chk($sformatf("basic ns beat%0d data", b), ns_data, ns_lit[b]);
            chk($sformatf("basic ns beat%0d last", b), 32'(ns_last), 32'(b == 5));
            chk($sformatf("basic ns beat%0d index", b), 32'(ns_idx), 32'(b));
            step();
        end
        chk("basic sq done valid", 32'(sq_valid), 32'd0);
        chk("basic ns done busy", 32'(ns_busy), 32'd0);

        // Backpressure
        m_ready   = 1'b0;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        acc_sq = 0;
        acc_ns = 0;
        for (int c = 0; c < 15; c++) begin
            m_ready = (c < 7) ? pat[c] : 1'b1;
            if (sq_valid && m_ready) acc_sq++;
            if (ns_valid && m_ready) acc_ns++;
            step();
        end
        chk("backpressure sq beats", 32'(acc_sq), 32'd4);
        chk("backpressure ns beats", 32'(acc_ns), 32'd6);

        // Ack protocol: res_ready held for 10 cycles -> one capture
        m_ready    = 1'b1;
        res_ready  = 1'b1;
        caps       = 0;
        prev_valid = sq_valid;
        for (int c = 0; c < 10; c++) begin
            step();
            if (sq_valid && !prev_valid) caps++;
            prev_valid = sq_valid;
        end
        chk("ack single capture", 32'(caps), 32'd1);
        chk("ack held high", 32'(sq_ack), 32'd1);
        res_ready = 1'b0;
        step();
        chk("ack released", 32'(sq_ack), 32'd0);

        // New result offered while streaming is stalled -> deferred
        m_ready   = 1'b0;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        step();
        res_ready = 1'b1;
        repeat (3) step();
        chk("deferred no ack", 32'(sq_ack), 32'd0);
        chk("deferred index held", 32'(sq_idx), 32'd0);
        m_ready    = 1'b1;
        saw_idle   = 1'b0;
        recaptured = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (!sq_valid) saw_idle = 1'b1;
            if (saw_idle && sq_valid) recaptured = 1'b1;
        end
        chk("deferred capture after idle", 32'(recaptured), 32'd1);
        res_ready = 1'b0;
        repeat (12) step();

        // Asynchronous reset mid-stream after two beats
        sq_res_data = {$urandom, $urandom, $urandom, $urandom};
        ns_res_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        res_ready = 1'b1;
        m_ready   = 1'b1;
        step();
        res_ready = 1'b0;
        step();
        step();
        chk("pre-reset sq index", 32'(sq_idx), 32'd2);
        #2;
        rst = 1'b0;
        #1;
        chk("async reset sq m_valid", 32'(sq_valid), 32'd0);
        chk("async reset sq busy", 32'(sq_busy), 32'd0);
        chk("async reset sq m_index", 32'(sq_idx), 32'd0);
        chk("async reset sq m_data", sq_data, 32'd0);
        chk("async reset ns m_valid", 32'(ns_valid), 32'd0);
        step();
        rst = 1'b1;
        sq_res_data = {$urandom, $urandom, $urandom, $urandom};
        res_ready = 1'b1;
        step();
        chk("restart sq m_index", 32'(sq_idx), 32'd0);
        chk("restart sq m_valid", 32'(sq_valid), 32'd1);
        chk("restart sq m_data", sq_data, sq_res_data[31:0]);
        res_ready = 1'b0;
        repeat (10) step();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            res_ready   = ($urandom_range(0, 2) != 0);
            m_ready     = ($urandom_range(0, 3) != 0);
            sq_res_data = {$urandom, $urandom, $urandom, $urandom};
            ns_res_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            step();
        end
        res_ready = 1'b0;
        m_ready   = 1'b1;
        repeat (12) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
